harris_corner_collector: RTL and testbench

- Streaming back end of the Harris pipeline.
- Consumes one signed Harris score per valid cycle in raster order and tracks pixel coordinates internally.
- Applies a runtime threshold and optional 1x3 horizontal non-maximum suppression, then queues corner records `(x, y, score)` in a FIFO with a ready/valid output.
- Keeps per-frame corner and drop statistics; this is the synthesizable successor of the simulation-only score printer.

---
 rtl/harris_pkg.sv | 19 +
 rtl/harris_corner_collector_if.sv | 15 +
 rtl/corner_fifo.sv | 46 ++++
 rtl/harris_corner_collector.sv | 127 ++++++++++++
 tb/tb_harris_corner_collector.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/harris_pkg.sv
// Shared types and helpers for the Harris gradient/score/collector blocks.
package harris_pkg;

    localparam int R_W_DEFAULT   = 64;
    localparam int IMG_W_DEFAULT = 640;
    localparam int IMG_H_DEFAULT = 480;

    // Coordinate width; a single-valued range still needs one bit.
    function automatic int coord_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [coord_w(IMG_W_DEFAULT)-1:0] x;
        logic [coord_w(IMG_H_DEFAULT)-1:0] y;
        logic signed [R_W_DEFAULT-1:0]     score;
    } corner_t;

endpackage

// File: rtl/harris_corner_collector_if.sv
// Corner record stream leaving the collector (ready/valid).
interface harris_corner_collector_if #(
    parameter int XW  = 10,
    parameter int YW  = 9,
    parameter int R_W = 64
);
    logic                  out_valid;
    logic                  out_ready;
    logic [XW-1:0]         out_x;
    logic [YW-1:0]         out_y;
    logic signed [R_W-1:0] out_score;

    modport master (output out_valid, out_x, out_y, out_score, input out_ready);
    modport slave  (input out_valid, out_x, out_y, out_score, output out_ready);
endinterface

// File: rtl/corner_fifo.sv
// Synchronous show-ahead FIFO of corner records; push while full is discarded
// unless a pop frees the slot in the same cycle.
module corner_fifo
    import harris_pkg::*;
#(
    parameter type T     = corner_t,
    parameter int  DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T           mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Head reads as zero while empty so outputs are clean after reset.
    assign dout = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/harris_corner_collector.sv
// Streaming Harris back end: raster coordinates, threshold + optional 1x3
// horizontal NMS, detection register, corner FIFO and per-frame statistics.
module harris_corner_collector
    import harris_pkg::*;
#(
    parameter int R_W        = R_W_DEFAULT,
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter bit NMS_EN     = 1'b1,
    localparam int XW        = coord_w(IMG_W),
    localparam int YW        = coord_w(IMG_H)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [R_W-1:0] thresh,
    input  logic                  r_valid,
    input  logic signed [R_W-1:0] r_score,
    harris_corner_collector_if.master cout,
    output logic [31:0]           corner_count,
    output logic [15:0]           drop_count,
    output logic                  frame_done
);
    typedef struct packed {
        logic [XW-1:0]         x;
        logic [YW-1:0]         y;
        logic signed [R_W-1:0] score;
    } det_t;

    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  last_x, last_y;
    logic signed [R_W-1:0] s1, s2;       // scores at columns x-1 and x-2
    logic                  hit;
    logic [XW-1:0]         hit_x;
    logic signed [R_W-1:0] hit_score;
    logic                  det_vld, clr_q, drop;
    det_t                  det, head;
    logic                  fifo_full, fifo_empty;

    assign last_x = (x == XW'(IMG_W - 1));
    assign last_y = (y == YW'(IMG_H - 1));

    // The current column gates the window: x==0 has no left pixel in this
    // row, x<2 means the decided pixel's left neighbour is off-row.
    always_comb begin
        hit       = 1'b0;
        hit_x     = x;
        hit_score = r_score;
        if (r_valid) begin
            if (NMS_EN) begin
                if (x != '0 && s1 > thresh && (x < XW'(2) || s1 >= s2) && s1 > r_score) begin
                    hit       = 1'b1;
                    hit_x     = x - XW'(1);
                    hit_score = s1;
                end else if (last_x && r_score > thresh && r_score >= s1) begin
                    hit = 1'b1;
                end
            end else if (r_score > thresh) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            s1         <= '0;
            s2         <= '0;
            det_vld    <= 1'b0;
            det        <= '0;
            clr_q      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            det_vld    <= hit;
            if (hit) det <= '{x: hit_x, y: y, score: hit_score};
            clr_q      <= r_valid && (x == '0) && (y == '0);
            frame_done <= r_valid && last_x && last_y;
            if (r_valid) begin
                s2 <= s1;
                s1 <= r_score;
                if (last_x) begin
                    x <= '0;
                    y <= last_y ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    corner_fifo #(.T(det_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (det_vld),
        .din   (det),
        .pop   (cout.out_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cout.out_valid = !fifo_empty;
    assign cout.out_x     = head.x;
    assign cout.out_y     = head.y;
    assign cout.out_score = head.score;

    // A full FIFO only loses the record when the head is not leaving this cycle.
    assign drop = det_vld && fifo_full && !cout.out_ready;

    // clr_q travels with the (0,0) sample's detection, so the clear lands first
    // and that sample's own contribution is added on top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corner_count <= '0;
            drop_count   <= '0;
        end else if (clr_q) begin
            corner_count <= {31'b0, det_vld};
            drop_count   <= {15'b0, drop};
        end else begin
            if (det_vld && corner_count != '1) corner_count <= corner_count + 32'd1;
            if (drop && drop_count != '1)      drop_count   <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_harris_corner_collector.sv
// Two collectors (threshold-only and NMS) on a 4x2 image, checked against a
// frame-level reference model.
module tb_harris_corner_collector;
    import harris_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 4;
    localparam int RW = 64;
    localparam int XW = coord_w(W);
    localparam int YW = coord_w(H);

    typedef struct { int x; int y; longint s; } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic signed [RW-1:0] thresh, r_score;
    logic r_valid, out_ready;
    logic [31:0] cc0, cc1;
    logic [15:0] dc0, dc1;
    logic        fd0, fd1;

    always #5 clk = ~clk;

    harris_corner_collector_if #(.XW(XW), .YW(YW), .R_W(RW)) ifc0 (), ifc1 ();
    assign ifc0.out_ready = out_ready;
    assign ifc1.out_ready = out_ready;

    harris_corner_collector #(.R_W(RW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .NMS_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .thresh(thresh), .r_valid(r_valid), .r_score(r_score),
        .cout(ifc0.master), .corner_count(cc0), .drop_count(dc0), .frame_done(fd0));
    harris_corner_collector #(.R_W(RW), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .NMS_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .thresh(thresh), .r_valid(r_valid), .r_score(r_score),
        .cout(ifc1.master), .corner_count(cc1), .drop_count(dc1), .frame_done(fd1));

    logic                 ov [2];
    logic [XW-1:0]        ox [2];
    logic [YW-1:0]        oy [2];
    logic signed [RW-1:0] os [2];
    logic [31:0]          cc [2];
    logic [15:0]          dc [2];
    logic                 fd [2];
    assign ov[0] = ifc0.out_valid; assign ov[1] = ifc1.out_valid;
    assign ox[0] = ifc0.out_x;     assign ox[1] = ifc1.out_x;
    assign oy[0] = ifc0.out_y;     assign oy[1] = ifc1.out_y;
    assign os[0] = ifc0.out_score; assign os[1] = ifc1.out_score;
    assign cc[0] = cc0; assign cc[1] = cc1;
    assign dc[0] = dc0; assign dc[1] = dc1;
    assign fd[0] = fd0; assign fd[1] = fd1;

    int     npass, ntot;
    rec_t   got [2][$];
    rec_t   exp [2][$];
    int     fdn [2] = '{0, 0};
    longint frm [W*H];

    // Records accepted by the consumer, sampled mid-cycle before the pop edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ov[d] && out_ready) got[d].push_back('{x: int'(ox[d]), y: int'(oy[d]), s: longint'(os[d])});
            if (fd[d]) fdn[d]++;
        end
    end

    function automatic string q2s(input rec_t q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("(%0d,%0d,%0d)", q[i].x, q[i].y, q[i].s)};
        return s;
    endfunction

    // Reference: a pixel is a corner if above threshold and, with NMS, a
    // row-local maximum (>= left, > right, off-row neighbours are -inf).
    task automatic model(input longint th);
        exp[0].delete();
        exp[1].delete();
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                longint s = frm[yy*W + xx];
                bit lok = (xx == 0)     || (s >= frm[yy*W + xx - 1]);
                bit rok = (xx == W - 1) || (s >  frm[yy*W + xx + 1]);
                if (s > th) begin
                    exp[0].push_back('{x: xx, y: yy, s: s});
                    if (lok && rok) exp[1].push_back('{x: xx, y: yy, s: s});
                end
            end
        end
    endtask

    task automatic send(input longint s);
        r_valid = 1'b1;
        r_score = s;
        @(posedge clk); #1;
        r_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_frame(input longint th, input bit gaps);
        thresh = th;
        got[0].delete();
        got[1].delete();
        model(th);
        for (int i = 0; i < W*H; i++) begin
            send(frm[i]);
            if (gaps) idle($urandom_range(0, 2));
        end
        idle(6);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if ({ov[d], ox[d], oy[d], os[d], cc[d], dc[d], fd[d]} !== '0)
                $display("FAIL reset_held dut%0d: v=%0b x=%0d y=%0d s=%0d cc=%0d dc=%0d fd=%0b, want all 0",
                         d, ov[d], ox[d], oy[d], os[d], cc[d], dc[d], fd[d]);
            else npass++;
        end
        reset = 1'b1;
        idle(2);
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if ({ov[d], ox[d], oy[d], os[d], cc[d], dc[d], fd[d]} !== '0)
                $display("FAIL reset_idle dut%0d: v=%0b x=%0d y=%0d s=%0d cc=%0d dc=%0d fd=%0b, want all 0",
                         d, ov[d], ox[d], oy[d], os[d], cc[d], dc[d], fd[d]);
            else npass++;
        end
    endtask

    task automatic test_thresh_only();
        frm = '{0, 65537, 65536, -5, -100, -100, -100, -100};
        run_frame(65536, 1'b0);
        ntot++;
        if (q2s(got[0]) != "(1,0,65537)") $display("FAIL thr_spec dut0: got %s want (1,0,65537)", q2s(got[0]));
        else npass++;
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != q2s(exp[d])) $display("FAIL thr_rec dut%0d: got %s want %s", d, q2s(got[d]), q2s(exp[d]));
            else npass++;
            ntot++;
            if (cc[d] !== 32'(exp[d].size()) || dc[d] !== 16'd0)
                $display("FAIL thr_cnt dut%0d: cc=%0d dc=%0d want %0d/0", d, cc[d], dc[d], exp[d].size());
            else npass++;
        end
    endtask

    task automatic test_nms_plateau();
        frm = '{10, 20, 20, 5, -50, -50, -50, -50};
        thresh = 0;
        got[0].delete();
        got[1].delete();
        model(0);
        for (int i = 0; i < W; i++) send(frm[i]);
        ntot++;
        if (ov[1] !== 1'b0) $display("FAIL plat_early: out_valid=%0b want 0 one cycle after x=3", ov[1]);
        else npass++;
        idle(1);
        ntot++;
        if (ov[1] !== 1'b1 || ox[1] !== XW'(2) || os[1] !== 64'sd20)
            $display("FAIL plat_head: v=%0b x=%0d s=%0d want 1/2/20 two cycles after x=3", ov[1], ox[1], os[1]);
        else npass++;
        for (int i = W; i < W*H; i++) send(frm[i]);
        idle(6);
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != q2s(exp[d])) $display("FAIL plat_rec dut%0d: got %s want %s", d, q2s(got[d]), q2s(exp[d]));
            else npass++;
        end
    endtask

    task automatic test_row_boundary();
        int fd_start [2];
        frm = '{1, 2, 3, 100, 200, 50, 0, 0};
        thresh = 0;
        got[0].delete();
        got[1].delete();
        model(0);
        fd_start = fdn;
        for (int i = 0; i < W*H; i++) send(frm[i]);
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (fd[d] !== 1'b1) $display("FAIL fdone_hi dut%0d: frame_done=%0b want 1 after last pixel", d, fd[d]);
            else npass++;
        end
        idle(6);
        ntot++;
        if (q2s(got[1]) != "(3,0,100)(0,1,200)") $display("FAIL row_spec dut1: got %s want (3,0,100)(0,1,200)", q2s(got[1]));
        else npass++;
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != q2s(exp[d])) $display("FAIL row_rec dut%0d: got %s want %s", d, q2s(got[d]), q2s(exp[d]));
            else npass++;
            ntot++;
            if (fdn[d] - fd_start[d] != 1) $display("FAIL fdone_cnt dut%0d: %0d pulses want 1", d, fdn[d] - fd_start[d]);
            else npass++;
        end
    endtask

    task automatic test_signed();
        frm = '{-5, -20, -10, -9, -100, -100, -100, -100};
        run_frame(-10, 1'b0);
        ntot++;
        if (q2s(got[0]) != "(0,0,-5)(3,0,-9)") $display("FAIL sgn_spec dut0: got %s want (0,0,-5)(3,0,-9)", q2s(got[0]));
        else npass++;
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != q2s(exp[d])) $display("FAIL sgn_rec dut%0d: got %s want %s", d, q2s(got[d]), q2s(exp[d]));
            else npass++;
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            longint th = longint'($urandom_range(0, 8)) - 4;
            for (int i = 0; i < W*H; i++) frm[i] = longint'($urandom_range(0, 16)) - 8;
            run_frame(th, 1'b1);
            for (int d = 0; d < 2; d++) begin
                ntot++;
                if (q2s(got[d]) != q2s(exp[d]))
                    $display("FAIL rnd_rec f%0d dut%0d: got %s want %s", f, d, q2s(got[d]), q2s(exp[d]));
                else npass++;
                ntot++;
                if (cc[d] !== 32'(exp[d].size()) || dc[d] !== 16'd0)
                    $display("FAIL rnd_cnt f%0d dut%0d: cc=%0d dc=%0d want %0d/0", f, d, cc[d], dc[d], exp[d].size());
                else npass++;
            end
        end
    endtask

    task automatic test_fifo_full();
        out_ready = 1'b0;
        thresh = 0;
        for (int i = 1; i <= 6; i++) send(i);
        idle(3);
        ntot++;
        if (cc[0] !== 32'd6 || dc[0] !== 16'd2) $display("FAIL full_cnt dut0: cc=%0d dc=%0d want 6/2", cc[0], dc[0]);
        else npass++;
        ntot++;
        if (cc[1] !== 32'd1 || dc[1] !== 16'd0) $display("FAIL full_cnt dut1: cc=%0d dc=%0d want 1/0", cc[1], dc[1]);
        else npass++;
        idle(2);
        ntot++;
        if (ov[0] !== 1'b1 || ox[0] !== '0 || oy[0] !== '0 || os[0] !== 64'sd1)
            $display("FAIL full_hold dut0: v=%0b x=%0d y=%0d s=%0d want 1/0/0/1", ov[0], ox[0], oy[0], os[0]);
        else npass++;
        got[0].delete();
        got[1].delete();
        out_ready = 1'b1;
        idle(8);
        exp[0] = '{'{x: 0, y: 0, s: 1}, '{x: 1, y: 0, s: 2}, '{x: 2, y: 0, s: 3}, '{x: 3, y: 0, s: 4}};
        exp[1] = '{'{x: 3, y: 0, s: 4}};
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != q2s(exp[d])) $display("FAIL full_drain dut%0d: got %s want %s", d, q2s(got[d]), q2s(exp[d]));
            else npass++;
        end
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        thresh = 0;
        send(-1);
        send(5);
        send(6);
        idle(3);
        ntot++;
        if (ov[0] !== 1'b1) $display("FAIL mid_pre dut0: out_valid=%0b want 1 before reset", ov[0]);
        else npass++;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (ov[d] !== 1'b0 || cc[d] !== '0 || dc[d] !== '0)
                $display("FAIL mid_clear dut%0d: v=%0b cc=%0d dc=%0d want 0/0/0", d, ov[d], cc[d], dc[d]);
            else npass++;
        end
        out_ready = 1'b1;
        frm = '{7, -1, -1, -1, -1, -1, -1, -1};
        run_frame(0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            ntot++;
            if (q2s(got[d]) != "(0,0,7)") $display("FAIL mid_after dut%0d: got %s want (0,0,7)", d, q2s(got[d]));
            else npass++;
        end
    endtask

    initial begin
        npass     = 0;
        ntot      = 0;
        reset     = 1'b0;
        r_valid   = 1'b0;
        r_score   = '0;
        thresh    = '0;
        out_ready = 1'b1;
        idle(3);
        test_reset();
        test_thresh_only();
        test_nms_plateau();
        test_row_boundary();
        test_signed();
        test_random();
        test_fifo_full();
        test_reset_midframe();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
